// File: rtl/ll_rx_credit_fifo_pkg.sv
// Shared types and helpers for the logic-link receive credit FIFO.
package ll_rx_pkg;

    typedef enum logic [1:0] {
        RX_OFFLINE = 2'd0,
        RX_INIT    = 2'd1,
        RX_RUN     = 2'd2
    } rx_state_e;

    // Counter width able to hold the value n itself (0..n).
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ll_rx_credit_fifo_if.sv
// Link-side push, user-side valid/ready and credit return of one receive channel.
interface ll_rx_credit_fifo_if #(
    parameter int WIDTH = 149
);
    logic             rx_push;
    logic [WIDTH-1:0] rx_push_data;
    logic             user_valid;
    logic [WIDTH-1:0] rxfifo_data;
    logic             user_ready;
    logic             tx_credit;

    modport master (
        output rx_push, rx_push_data, user_ready,
        input  user_valid, rxfifo_data, tx_credit
    );

    modport slave (
        input  rx_push, rx_push_data, user_ready,
        output user_valid, rxfifo_data, tx_credit
    );
endinterface

// File: rtl/ll_rx_credit_fifo_mem.sv
// Register-array FIFO storage with wrapping pointers and occupancy count.
module ll_rx_fifo_mem #(
    parameter int WIDTH  = 149,
    parameter int DEPTH  = 8,
    parameter int AWIDTH = $clog2(DEPTH),
    parameter int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [CWIDTH-1:0] count,
    output logic              full,
    output logic              empty
);
    localparam logic [CWIDTH-1:0] DEPTH_C = CWIDTH'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AWIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CWIDTH'(1);
                2'b01:   count <= count - CWIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/ll_rx_credit_fifo.sv
// Per-channel receive buffer: link bring-up sequencing, credit return and overflow tracking.
module ll_rx_credit_fifo
    import ll_rx_pkg::*;
#(
    parameter int WIDTH  = 149,
    parameter int DEPTH  = 8,
    parameter int AWIDTH = $clog2(DEPTH),
    parameter int CWIDTH = clog2p1(DEPTH)
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr,
    input  logic                  rx_online,
    ll_rx_credit_fifo_if.slave    bus,
    output logic [CWIDTH-1:0]     fifo_count,
    output logic                  overflow_err
);
    localparam logic [CWIDTH-1:0] DEPTH_C = CWIDTH'(DEPTH);

    rx_state_e         state;
    logic [CWIDTH-1:0] credit_owed;
    logic [CWIDTH-1:0] owed_next;
    logic              tx_credit_q;
    logic              pop;
    logic              push_ok;
    logic              full;
    logic              empty;

    assign pop     = !empty && bus.user_ready;
    assign push_ok = (state != RX_OFFLINE) && bus.rx_push && (!full || pop);

    // A pop and an issued credit in the same cycle cancel out.
    assign owed_next = credit_owed + CWIDTH'(pop) - CWIDTH'(tx_credit_q);

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state        <= RX_OFFLINE;
            credit_owed  <= '0;
            tx_credit_q  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if ((state != RX_OFFLINE) && bus.rx_push && full && !pop) begin
                overflow_err <= 1'b1;
            end
            if (!rx_online) begin
                state       <= RX_OFFLINE;
                credit_owed <= '0;
                tx_credit_q <= 1'b0;
            end else begin
                case (state)
                    RX_OFFLINE: begin
                        state       <= RX_INIT;
                        credit_owed <= DEPTH_C;
                        tx_credit_q <= 1'b1;
                    end
                    RX_INIT: begin
                        credit_owed <= owed_next;
                        tx_credit_q <= (owed_next != '0);
                        if (owed_next == '0) begin
                            state <= RX_RUN;
                        end
                    end
                    RX_RUN: begin
                        credit_owed <= owed_next;
                        tx_credit_q <= (owed_next != '0);
                    end
                    default: begin
                        state       <= RX_OFFLINE;
                        credit_owed <= '0;
                        tx_credit_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    ll_rx_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH),
        .CWIDTH (CWIDTH)
    ) u_mem (
        .clk   (clk_wr),
        .rst   (rst_wr),
        .flush (!rx_online),
        .push  (push_ok),
        .pop   (pop),
        .wdata (bus.rx_push_data),
        .rdata (bus.rxfifo_data),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign bus.user_valid = !empty;
    assign bus.tx_credit  = tx_credit_q;

endmodule
